// File: rtl/keccak_state_dma.sv
// OBI master that moves one Keccak state between memory and the state buffer,
// optionally running the permutation in between, then raises a completion pulse.
module keccak_state_dma #(
    parameter int NWORDS          = 50,
    parameter int MAX_OUTSTANDING = 2,
    parameter int IDX_W           = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    output logic             obi_req_o,
    input  logic             obi_gnt_i,
    output logic [31:0]      obi_addr_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    output logic             state_we_o,
    output logic [IDX_W-1:0] state_idx_o,
    output logic [31:0]      state_wdata_o,
    input  logic [31:0]      state_rdata_i,
    output logic             perm_start_o,
    input  logic             perm_done_i,
    output logic             busy_o,
    output logic             intr_o
);
    // One extra bit so the counters can hold NWORDS itself.
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] NWORDS_C = CNT_W'(NWORDS);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] MAXOUT_C = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE, LOAD, PERM_START, PERM_WAIT, STORE, FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] resp_q, resp_d;
    logic [CNT_W-1:0] outstanding;
    logic [31:0]      word_off;
    logic             xfer, gnt_hit, rsp_hit, last_rsp;

    assign outstanding = issue_q - resp_q;
    assign word_off    = 32'({issue_q, 2'b00});
    assign xfer        = (state_q == LOAD) || (state_q == STORE);
    // The request depends only on registered counters, so once raised it cannot
    // fall before the grant: issue_q is frozen and outstanding can only shrink.
    assign obi_req_o   = xfer && (issue_q < NWORDS_C) && (outstanding < MAXOUT_C);
    assign gnt_hit     = obi_req_o && obi_gnt_i;
    // Unsolicited responses never advance the response count.
    assign rsp_hit     = xfer && obi_rvalid_i && (outstanding != '0);
    assign last_rsp    = rsp_hit && (resp_q == LAST_C);
    assign obi_be_o    = 4'hF;

    always_comb begin
        obi_addr_o    = '0;
        obi_we_o      = 1'b0;
        obi_wdata_o   = '0;
        state_we_o    = 1'b0;
        state_idx_o   = '0;
        state_wdata_o = '0;
        perm_start_o  = 1'b0;
        intr_o        = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                obi_addr_o    = src_q + word_off;
                state_we_o    = rsp_hit;
                state_idx_o   = resp_q[IDX_W-1:0];
                state_wdata_o = obi_rdata_i;
            end
            STORE: begin
                obi_addr_o  = dst_q + word_off;
                obi_we_o    = 1'b1;
                state_idx_o = issue_q[IDX_W-1:0];
                obi_wdata_o = state_rdata_i;
            end
            PERM_START: perm_start_o = 1'b1;
            FINISH:     intr_o       = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        issue_d = issue_q + CNT_W'(gnt_hit);
        resp_d  = resp_q + CNT_W'(rsp_hit);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    src_d  = src_addr_i & 32'hFFFF_FFFC;
                    dst_d  = dst_addr_i & 32'hFFFF_FFFC;
                    case (mode_i)
                        2'b10:   state_d = STORE;
                        2'b11:   state_d = PERM_START;
                        default: state_d = LOAD;
                    endcase
                end
            end
            LOAD: begin
                if (last_rsp) begin
                    issue_d = '0;
                    resp_d  = '0;
                    state_d = (mode_q == 2'b01) ? FINISH : PERM_START;
                end
            end
            PERM_START: state_d = PERM_WAIT;
            PERM_WAIT: begin
                if (perm_done_i) state_d = STORE;
            end
            STORE: begin
                if (last_rsp) begin
                    issue_d = '0;
                    resp_d  = '0;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            issue_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            issue_q <= issue_d;
            resp_q  <= resp_d;
        end
    end
endmodule

// File: tb/tb_keccak_state_dma.sv
// Self-checking bench: randomized OBI memory slave, permutation stub and a
// transfer-level reference of expected reads, writes and buffer contents.
module tb_keccak_state_dma;
    localparam int NW   = 50;
    localparam int MAXO = 2;
    localparam int IW   = 6;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [31:0]   src_addr_i = '0, dst_addr_i = '0;
    logic          obi_req_o, obi_we_o;
    logic          obi_gnt_i = 1'b0;
    logic [31:0]   obi_addr_o, obi_wdata_o;
    logic [3:0]    obi_be_o;
    logic          obi_rvalid_i = 1'b0;
    logic [31:0]   obi_rdata_i = '0;
    logic          state_we_o;
    logic [IW-1:0] state_idx_o;
    logic [31:0]   state_wdata_o, state_rdata_i;
    logic          perm_start_o, busy_o, intr_o;
    logic          perm_done_i = 1'b0;

    keccak_state_dma #(.NWORDS(NW), .MAX_OUTSTANDING(MAXO), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .state_we_o(state_we_o), .state_idx_o(state_idx_o),
        .state_wdata_o(state_wdata_o), .state_rdata_i(state_rdata_i),
        .perm_start_o(perm_start_o), .perm_done_i(perm_done_i),
        .busy_o(busy_o), .intr_o(intr_o)
    );

    initial forever #5 clk = ~clk;

    int    n_checks = 0, n_err = 0, cyc = 0;
    string cur = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", cur, tag, obs, exp);
        end
    endtask

    // State buffer: combinational read, written on the clock edge.
    logic [31:0] sbuf [64];
    assign state_rdata_i = sbuf[state_idx_o];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) sbuf[i] <= $urandom;
        end else if (state_we_o) begin
            sbuf[state_idx_o] <= state_wdata_o;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    txn_t        rsp_q[$];
    txn_t        rd_log[$];
    txn_t        wr_log[$];
    logic [31:0] mem [logic [31:0]];
    int          gmax = 0, rlat = 1, gwait = 0;
    bit          inject_rv = 0;
    int          last_rv_cyc = 0, last_rd_rv_cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // OBI memory slave: random grant delay, fixed in-order response latency.
    initial begin
        txn_t        t;
        bit          pend;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        pend = 0;
        forever begin
            @(negedge clk);
            obi_gnt_i    = 1'b0;
            obi_rvalid_i = 1'b0;
            obi_rdata_i  = $urandom;
            if (rst_i) begin
                pend = 0;
            end else begin
                if (pend) begin
                    chk("req_held", 32'(obi_req_o), 32'd1);
                    chk("addr_held", obi_addr_o, p_addr);
                    chk("we_held", 32'(obi_we_o), 32'(p_we));
                    chk("wdata_held", obi_wdata_o, p_wdata);
                end
                pend = 0;
                if (obi_req_o) begin
                    if (gwait == 0) begin
                        chk("outstanding_ok", 32'(rsp_q.size() < MAXO), 32'd1);
                        chk("be", 32'(obi_be_o), 32'hF);
                        obi_gnt_i = 1'b1;
                        t.addr = obi_addr_o;
                        t.we   = obi_we_o;
                        t.data = obi_wdata_o;
                        t.cyc  = cyc;
                        if (obi_we_o) begin
                            mem[obi_addr_o] = obi_wdata_o;
                            wr_log.push_back(t);
                        end else begin
                            rd_log.push_back(t);
                        end
                        t.cyc = cyc + rlat;
                        rsp_q.push_back(t);
                        gwait = $urandom_range(gmax, 0);
                    end else begin
                        gwait--;
                        pend    = 1;
                        p_addr  = obi_addr_o;
                        p_we    = obi_we_o;
                        p_wdata = obi_wdata_o;
                    end
                end
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                t = rsp_q.pop_front();
                obi_rvalid_i = 1'b1;
                obi_rdata_i  = t.we ? $urandom : mem_rd(t.addr);
                last_rv_cyc  = cyc;
                if (!t.we) last_rd_rv_cyc = cyc;
            end else if (inject_rv) begin
                obi_rvalid_i = 1'b1;
                inject_rv    = 0;
            end
        end
    end

    // Permutation stub: done pulse perm_delay cycles after each start pulse.
    int perm_delay = 10, pd_cnt = 0, perm_start_cnt = 0, perm_start_cyc = -1, done_cyc = -1;
    bit inject_done = 0;
    initial forever begin
        @(negedge clk);
        perm_done_i = 1'b0;
        if (inject_done) begin
            perm_done_i = 1'b1;
            inject_done = 0;
        end
        if (pd_cnt > 0) begin
            pd_cnt--;
            if (pd_cnt == 0) begin
                perm_done_i = 1'b1;
                done_cyc    = cyc;
            end
        end
        if (perm_start_o) begin
            pd_cnt = perm_delay;
            perm_start_cnt++;
            perm_start_cyc = cyc;
        end
    end

    int we_cnt = 0, intr_cnt = 0;
    initial forever begin
        @(negedge clk);
        #2;
        if (state_we_o) we_cnt++;
        if (intr_o) intr_cnt++;
    end

    task automatic do_run(input string name, input logic [1:0] m, input logic [31:0] src,
                          input logic [31:0] dst, input int gm, input int rl,
                          input bit poke_start, input bit inject_pd);
        logic [31:0] exp_buf [NW];
        logic [31:0] sb, db;
        bit          load_m, store_m, seen, poked, injected;
        int          n, start_cyc, intr_cyc;
        cur     = name;
        sb      = src & 32'hFFFF_FFFC;
        db      = dst & 32'hFFFF_FFFC;
        load_m  = (m == 2'b00) || (m == 2'b01);
        store_m = (m != 2'b01);
        for (int k = 0; k < NW; k++)
            exp_buf[k] = load_m ? mem_rd(sb + 32'(4 * k)) : sbuf[k];
        gmax = gm; rlat = rl; gwait = 0;
        rd_log.delete(); wr_log.delete();
        we_cnt = 0; intr_cnt = 0; perm_start_cnt = 0; perm_start_cyc = -1; done_cyc = -1;
        start_i = 1'b1; mode_i = m; src_addr_i = src; dst_addr_i = dst;
        start_cyc = cyc;
        seen = 0; poked = 0; injected = 0; n = 0; intr_cyc = 0;
        while (!seen && n < 4000) begin
            @(negedge clk);
            n++;
            start_i = 1'b0;
            if (n == 1) chk("busy_after_start", 32'(busy_o), 32'd1);
            if (poke_start && !poked && wr_log.size() >= 10) begin
                start_i = 1'b1; mode_i = 2'b00; poked = 1;
            end
            if (inject_pd && !injected && rd_log.size() == 5) begin
                inject_done = 1; injected = 1;
            end
            if (intr_o) begin
                seen = 1; intr_cyc = cyc;
            end
        end
        start_i = 1'b0;
        chk("intr_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("busy_after_intr", 32'(busy_o), 32'd0);
        chk("intr_one_cycle", 32'(intr_o), 32'd0);
        repeat (4) @(negedge clk);
        chk("intr_count", 32'(intr_cnt), 32'd1);
        chk("intr_after_last_rsp", 32'(intr_cyc), 32'(last_rv_cyc + 1));
        chk("read_count", 32'(rd_log.size()), load_m ? 32'(NW) : 32'd0);
        for (int k = 0; k < rd_log.size() && k < NW; k++)
            chk($sformatf("rd_addr[%0d]", k), rd_log[k].addr, sb + 32'(4 * k));
        chk("state_we_count", 32'(we_cnt), load_m ? 32'(NW) : 32'd0);
        if (load_m)
            for (int k = 0; k < NW; k++)
                chk($sformatf("buf[%0d]", k), sbuf[k], exp_buf[k]);
        chk("write_count", 32'(wr_log.size()), store_m ? 32'(NW) : 32'd0);
        for (int k = 0; k < wr_log.size() && k < NW; k++) begin
            chk($sformatf("wr_addr[%0d]", k), wr_log[k].addr, db + 32'(4 * k));
            chk($sformatf("wr_data[%0d]", k), wr_log[k].data, exp_buf[k]);
        end
        chk("perm_start_count", 32'(perm_start_cnt), (m == 2'b00 || m == 2'b11) ? 32'd1 : 32'd0);
        if (m == 2'b11)
            chk("perm_start_time", 32'(perm_start_cyc), 32'(start_cyc + 1));
        if (m == 2'b00)
            chk("perm_after_load", 32'(perm_start_cyc), 32'(last_rd_rv_cyc + 1));
        if ((m == 2'b00 || m == 2'b11) && wr_log.size() > 0)
            chk("write_after_done", 32'(wr_log[0].cyc > done_cyc && done_cyc >= 0), 32'd1);
        $display("run %s: mode=%0d reads=%0d writes=%0d intr@%0d", name, m,
                 rd_log.size(), wr_log.size(), intr_cyc);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("busy", 32'(busy_o), 32'd0);
        chk("req", 32'(obi_req_o), 32'd0);
        chk("intr", 32'(intr_o), 32'd0);
        chk("perm_start", 32'(perm_start_o), 32'd0);
        chk("state_we", 32'(state_we_o), 32'd0);
        chk("we", 32'(obi_we_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        do_run("m00_basic", 2'b00, 32'h0000_1000, 32'h0000_2000, 0, 1, 0, 0);
        do_run("m00_backpressure", 2'b00, 32'h0000_7000, 32'h0000_8000, 5, 3, 0, 1);
        do_run("m01_unaligned", 2'b01, 32'h0000_3003, 32'h0, 0, 1, 0, 0);
        do_run("m10_start_poke", 2'b10, 32'h0, 32'h0000_9000, 3, 2, 1, 0);
        do_run("m11", 2'b11, 32'h0, 32'h0000_A000, 1, 1, 0, 0);
        do_run("m10_wrap", 2'b10, 32'h0, 32'hFFFF_FFE3, 2, 1, 0, 0);

        cur = "idle_rvalid";
        we_cnt = 0;
        inject_rv = 1;
        repeat (4) @(negedge clk);
        chk("state_we_count", 32'(we_cnt), 32'd0);
        chk("busy", 32'(busy_o), 32'd0);
        $display("idle rvalid injected: state_we=%0d busy=%0d", we_cnt, busy_o);

        cur = "mid_reset";
        gmax = 2; rlat = 2; gwait = 0;
        rd_log.delete(); wr_log.delete();
        start_i = 1'b1; mode_i = 2'b00; src_addr_i = 32'h0000_5000; dst_addr_i = 32'h0000_6000;
        n = 0;
        while (rd_log.size() < 20 && n < 2000) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
        end
        chk("reached_20_reads", 32'(rd_log.size() >= 20), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("busy", 32'(busy_o), 32'd0);
        chk("req", 32'(obi_req_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        n = 0;
        while (rsp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bus_drained", 32'(rsp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("reset at read %0d: busy=%0d req=%0d", rd_log.size(), busy_o, obi_req_o);
        do_run("m01_after_reset", 2'b01, 32'h0000_5000, 32'h0, 2, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
